frame_ram_arbiter: RTL
======================

Name: frame_ram_arbiter

Overview:
- Shares the single-port frame-buffer pixel RAM between two requesters: the video pixel-fetch path and the CPU bus.
- The video pixel-fetch path feeds 9-bit RRRGGGBBB words to the palette stage.
- The CPU bus writes and reads pixels.
- Video has priority; CPU requests are held in a 1-entry buffer and are guaranteed service by an anti-starvation counter.

Parameters:
- ADDR_W, 19, pixel address width (640x480 = 307200 words).
- DATA_W, 9, pixel width (3/3/3 RGB).
- STARVE_LIM, 15, consecutive video-won cycles a pending CPU op tolerates before a forced CPU slot.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- vid_req  in  1  video fetch request this cycle
- vid_addr  in  ADDR_W  video pixel address
- vid_ack  out  1  video address issued to RAM this cycle
- vid_valid  out  1  vid_data holds the pixel for the ack of the previous cycle
- vid_data  out  DATA_W  pixel to palette
- cpu_wr  in  1  CPU write request
- cpu_rd  in  1  CPU read request
- cpu_addr  in  ADDR_W  CPU pixel address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  holding buffer empty; request accepted this cycle
- cpu_rdata  out  DATA_W  last CPU read result (registered, held)
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata updated
- cpu_forced  out  1  this cycle's CPU slot was forced by starvation
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read-enable

Behaviour:
- Reset values:
  - pend=0, wait_cnt=0, vid_valid=0, rd_issued=0.
  - cpu_rvalid=0, cpu_rdata=0, cpu_ready=1.
  - vid_ack=0, ram_en=0, ram_we=0, cpu_forced=0.
- Reset mid-operation drops any pending CPU op; no RAM write occurs for it.
- CPU accept:
  - cpu_ready = ~pend.
  - If cpu_ready and (cpu_wr|cpu_rd): latch op/addr/wdata and set pend next cycle.
  - cpu_wr and cpu_rd together: treated as a write, read discarded.
  - Requests while cpu_ready=0 are ignored; the CPU must hold until ready.
- Grant (combinational each cycle, from registered pend/wait_cnt):
  - cpu_grant = pend & (~vid_req | wait_cnt==STARVE_LIM).
  - vid_grant = vid_req & ~cpu_grant.
  - A CPU op is issued no earlier than the cycle after acceptance.
- RAM drive:
  - On vid_grant: ram_en=1, ram_we=0, ram_addr=vid_addr.
  - On cpu_grant: ram_en=1, ram_we=op_is_write, ram_addr/ram_wdata from the holding buffer.
  - Otherwise ram_en=0, ram_we=0.
- vid_ack = vid_grant.
- cpu_forced = cpu_grant & vid_req.
- The video client must re-present an un-acked address on the next cycle.
- wait_cnt:
  - Increments when pend & vid_grant, saturating at STARVE_LIM.
  - Clears on cpu_grant or when ~pend.
- pend clears on cpu_grant. Back-to-back CPU ops are therefore at most one per 2 cycles.
- Video read latency: vid_valid is asserted exactly 1 cycle after vid_ack; vid_data = ram_rdata (pass-through).
- CPU read latency:
  - rd_issued is registered from cpu_grant & read.
  - In the cycle rd_issued=1, ram_rdata is captured into cpu_rdata.
  - cpu_rvalid pulses in the following cycle, 2 cycles after the grant.
  - cpu_rdata holds until the next read completes.
- Write-then-read to the same address in consecutive grants returns the new data (RAM write-first not required; reads are at least one cycle after the write).
- Address arithmetic: none. Addresses pass unmodified; range checking is the requester's responsibility.

Test Plan:
- CPU alone:
  - Stimulus: vid_req=0; cpu_wr addr=0x00123 data=0x1C7; then cpu_rd same address.
  - Response: write grant 1 cycle after accept with ram_we=1, wdata=0x1C7; read grant, then cpu_rvalid pulses 2 cycles later with cpu_rdata=0x1C7.
- Video streaming:
  - Stimulus: vid_req=1 continuously, addr 0..7.
  - Response: vid_ack every cycle; vid_valid 1 cycle later; vid_data sequence matches preloaded RAM 0..7.
- Starvation:
  - Stimulus: vid_req=1 continuously; cpu_wr accepted at cycle t.
  - Response: 15 video grants, then at t+16 cpu_grant with cpu_forced=1 and vid_ack=0; video resumes at t+17; wait_cnt back to 0.
- Blanking service:
  - Stimulus: cpu_wr pending; vid_req drops at cycle t.
  - Response: CPU granted at t, cpu_forced=0, cpu_ready=1 at t+1.
- Backpressure/simultaneous:
  - Stimulus: cpu_wr & cpu_rd together; second request while pend=1.
  - Response: only the write is performed; the second request is ignored until cpu_ready=1.
- Reset mid-op:
  - Stimulus: cpu_wr accepted while vid_req=1; assert reset for 1 cycle.
  - Response: no ram_we ever asserted for that op; all outputs at reset values; cpu_ready=1 after reset.

Source files
------------

// File: rtl/frame_ram_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, its two requesters and the pixel RAM.
// The slave modport is the arbiter's view; master is the clients' and RAM's view.
interface frame_ram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 9
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;

  logic              cpu_wr;
  logic              cpu_rd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_forced;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_wr, cpu_rd, cpu_addr, cpu_wdata, ram_rdata,
    output vid_ack, vid_valid, vid_data, cpu_ready, cpu_rdata, cpu_rvalid,
           cpu_forced, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_wr, cpu_rd, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_ack, vid_valid, vid_data, cpu_ready, cpu_rdata, cpu_rvalid,
           cpu_forced, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Single-port pixel RAM arbiter: video fetch has priority, CPU ops wait in a 1-entry
// buffer and get a forced slot after STARVE_LIM consecutive video wins.
module frame_ram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 9,
  parameter int STARVE_LIM = 15
) (
  input logic                clk,
  input logic                reset,
  frame_ram_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  // state  | meaning
  // S_IDLE | holding buffer empty, CPU may issue a request
  // S_PEND | CPU op latched, waiting for a RAM slot
  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_vid_valid;
  logic              r_rd_issued;
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic w_pend, w_accept, w_cpu_grant, w_vid_grant;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grants are suppressed while reset is held so a dropped op never reaches the RAM.
  always_comb begin
    w_state_nxt = r_state;
    w_pend      = (r_state == S_PEND);
    w_cpu_grant = w_pend & ~reset & (~bus.vid_req | (r_wait_cnt == LIM));
    w_vid_grant = bus.vid_req & ~reset & ~w_cpu_grant;
    w_accept    = ~w_pend & ~reset & (bus.cpu_wr | bus.cpu_rd);
    case (r_state)
      S_IDLE:  if (w_accept)    w_state_nxt = S_PEND;
      S_PEND:  if (w_cpu_grant) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_wr      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_vid_valid  <= 1'b0;
      r_rd_issued  <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_op_wr <= bus.cpu_wr;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
      if (!w_pend || w_cpu_grant)
        r_wait_cnt <= '0;
      else if (w_vid_grant && (r_wait_cnt != LIM))
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      r_vid_valid  <= w_vid_grant;
      r_rd_issued  <= w_cpu_grant & ~r_op_wr;
      r_cpu_rvalid <= r_rd_issued;
      if (r_rd_issued) r_cpu_rdata <= bus.ram_rdata;
    end
  end

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = r_wdata;
    if (w_cpu_grant) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = r_op_wr;
      bus.ram_addr = r_addr;
    end else if (w_vid_grant) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.vid_addr;
    end
  end

  assign bus.vid_ack    = w_vid_grant;
  assign bus.vid_valid  = r_vid_valid;
  assign bus.vid_data   = bus.ram_rdata;
  assign bus.cpu_ready  = ~w_pend | reset;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.cpu_forced = w_cpu_grant & bus.vid_req;
endmodule
